// File: rtl/serial_mag_comp.sv
// Serial unsigned magnitude comparator: one 2-bit digit per cycle, MSB first, one-hot result.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN: leave RUN at the first unequal digit.
module serial_mag_comp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             A_eq_B,
   output logic             A_ls_B,
   output logic             A_gt_B
);

   // state  | meaning
   // IDLE   | waiting for start; results from last comparison held
   // RUN    | one digit compared per cycle, index counting down
   // DONE   | one-cycle done pulse, busy still high

   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [WIDTH-1:0] a_r, b_r;
   logic [IW-1:0]  idx;
   logic           dec_lt, dec_gt;
   logic           accept, run_step, leave_run, last_digit;
   logic [1:0]     dig_a, dig_b;
   logic           lt_acc, gt_acc;
   logic [1:0]     dig_a_arr [N];
   logic [1:0]     dig_b_arr [N];

   for (genvar g = 0; g < N; g++) begin : g_digit
      assign dig_a_arr[g] = a_r[2*g +: 2];
      assign dig_b_arr[g] = b_r[2*g +: 2];
   end

   assign dig_a = dig_a_arr[idx];
   assign dig_b = dig_b_arr[idx];

   // An earlier decision is sticky; only the first unequal digit may set one.
   always_comb begin
      lt_acc     = dec_lt | (~dec_gt & (dig_a < dig_b));
      gt_acc     = dec_gt | (~dec_lt & (dig_a > dig_b));
      last_digit = (idx == '0);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
      leave_run  = last_digit | lt_acc | gt_acc;
`else
      leave_run  = last_digit;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      run_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            run_step = 1'b1;
            if (leave_run) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         idx    <= '0;
         dec_lt <= 1'b0;
         dec_gt <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         A_eq_B <= 1'b0;
         A_ls_B <= 1'b0;
         A_gt_B <= 1'b0;
      end else if (accept) begin
         a_r    <= a;
         b_r    <= b;
         idx    <= IW'(N - 1);
         dec_lt <= 1'b0;
         dec_gt <= 1'b0;
         busy   <= 1'b1;
         A_eq_B <= 1'b0;
         A_ls_B <= 1'b0;
         A_gt_B <= 1'b0;
      end else if (run_step) begin
         dec_lt <= lt_acc;
         dec_gt <= gt_acc;
         if (!last_digit) idx <= idx - 1'b1;
         if (leave_run) begin
            done   <= 1'b1;
            A_eq_B <= ~(lt_acc | gt_acc);
            A_ls_B <= lt_acc;
            A_gt_B <= gt_acc;
         end
      end else if (state == S_DONE) begin
         done <= 1'b0;
         busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: cycle-level behavioural model with per-cycle compare,
// directed literal cases and randomized start/operand/reset traffic.
module tb_serial_mag_comp;
   localparam int W = 8;
   localparam int N = W / 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, A_eq_B, A_ls_B, A_gt_B;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;

   serial_mag_comp #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .A_eq_B(A_eq_B), .A_ls_B(A_ls_B), .A_gt_B(A_gt_B)
   );

   always #5 clk = ~clk;

   // Position (1-based from MSB) of the first unequal digit, N if none.
   function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = N - k;
         if (x[2*i +: 2] != y[2*i +: 2]) return k;
      end
      return N;
   endfunction

   function automatic int latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
      return first_diff(x, y);
`else
      return N;
`endif
   endfunction

   // Behavioural model: a countdown from start acceptance to the done cycle.
   logic m_busy, m_done, m_eq, m_lt, m_gt;
   logic r_eq, r_lt, r_gt;
   int   m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_eq <= 0; m_lt <= 0; m_gt <= 0; m_cnt <= 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1; m_eq <= 0; m_lt <= 0; m_gt <= 0;
            m_cnt  <= latency(a, b);
            r_eq   <= (a == b);
            r_lt   <= (a < b);
            r_gt   <= (a > b);
         end
      end else if (m_done) begin
         m_done <= 0; m_busy <= 0;
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1; m_eq <= r_eq; m_lt <= r_lt; m_gt <= r_gt;
         end
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("busy",   busy,   m_busy);
      chk("done",   done,   m_done);
      chk("A_eq_B", A_eq_B, m_eq);
      chk("A_ls_B", A_ls_B, m_lt);
      chk("A_gt_B", A_gt_B, m_gt);
      if (done === 1'b1) done_seen++;
   end

   task automatic all_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_eq"},   A_eq_B, 1'b0);
      chk({tag, "_lt"},   A_ls_B, 1'b0);
      chk({tag, "_gt"},   A_gt_B, 1'b0);
   endtask

   // Start one comparison from IDLE and check latency and result against literals.
   task automatic directed(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic e_eq, input logic e_lt, input logic e_gt, input int e_lat);
      int k;
      int busy_cycles;
      @(negedge clk);
      a = xa; b = xb; start = 1;
      @(posedge clk);
      #1 start = 0; a = $urandom; b = $urandom;
      k = 0; busy_cycles = 0;
      while (k < 20) begin
         @(posedge clk); k++;
         #1;
         if (busy) busy_cycles++;
         if (done) break;
      end
      chk_int({tag, "_latency"}, k, e_lat);
      chk({tag, "_eq"}, A_eq_B, e_eq);
      chk({tag, "_lt"}, A_ls_B, e_lt);
      chk({tag, "_gt"}, A_gt_B, e_gt);
      @(posedge clk); #1;
      chk({tag, "_busy_drop"}, busy, 1'b0);
      chk({tag, "_done_drop"}, done, 1'b0);
      chk_int({tag, "_busy_cycles"}, busy_cycles + 1, e_lat + 1);
      chk({tag, "_hold"}, A_eq_B | A_ls_B | A_gt_B, 1'b1);
   endtask

   initial begin
      int d0;
      int lat40;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
      lat40 = 1;
`else
      lat40 = 4;
`endif
      // Reset with start held high and random operands.
      start = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         all_zero("reset");
      end
      @(negedge clk);
      start = 0; rst = 0;

      directed("eq_a5", 8'hA5, 8'hA5, 1, 0, 0, 4);
      directed("lt_40_80", 8'h40, 8'h80, 0, 1, 0, lat40);
      directed("gt_1f_1c", 8'h1F, 8'h1C, 0, 0, 1, 4);

      // Second start during RUN must be ignored.
      @(negedge clk);
      d0 = done_seen;
      a = 8'h10; b = 8'h20; start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1 a = 8'hFF; b = 8'h00; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (8) @(negedge clk);
      chk_int("ignore_done_pulses", done_seen - d0, 1);
      chk("ignore_lt", A_ls_B, 1'b1);
      chk("ignore_gt", A_gt_B, 1'b0);

      // Reset mid-RUN discards the comparison.
      @(negedge clk);
      d0 = done_seen;
      a = 8'h33; b = 8'h30; start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); @(posedge clk);
      #1 rst = 1;
      #1 all_zero("midrst");
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (6) @(negedge clk);
      chk_int("midrst_no_done", done_seen - d0, 0);
      directed("after_rst", 8'h02, 8'h01, 0, 0, 1, 4);

      // Randomized traffic: shared prefixes, stray starts, occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         a = $urandom;
         case ($urandom_range(3))
            0: b = a;
            1: b = a ^ (W'(1) << $urandom_range(W - 1));
            default: b = $urandom;
         endcase
         start = ($urandom_range(3) != 0);
         rst = ($urandom_range(199) == 0);
      end
      @(negedge clk);
      rst = 0; start = 0;
      repeat (10) @(negedge clk);
      if (done_seen < 50) chk_int("random_activity", done_seen, 50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
